// File: rtl/uart_pkg.sv
// Shared types and constants for the a0 UART logger.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BITS_PER_BYTE  = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, show-ahead read, wrap-bit pointers.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wp;
    logic [AW:0]      rp;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rd_en = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_en) wp <= wp + 1'b1;
            if (rd_en) rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/a0_uart_tx.sv
// Logs every new a0 value as four 8N1 bytes, LSB first.
module a0_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a0,
    input  logic        en,
    output logic        tx,
    output logic        busy,
    output logic        overflow
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    uart_state_t   state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic [31:0]   sh;
    logic [31:0]   prev_a0;
    logic [31:0]   dout;
    logic          capture;
    logic          pop;
    logic          full;
    logic          empty;
    logic          tick;

    assign capture = en && (a0 != prev_a0);
    assign pop     = (state == IDLE) && !empty;
    assign tick    = (timer == LAST);
    assign busy    = (state != IDLE) || !empty;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .pop   (pop),
        .din   (a0),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_a0  <= '0;
            overflow <= 1'b0;
        end else begin
            if (en) prev_a0 <= a0;
            if (capture && full && !pop) overflow <= 1'b1;
        end
    end

    // sh shifts right once per data bit, so sh[0] is always the next bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            timer    <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            sh       <= '0;
            tx       <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    timer <= '0;
                    if (!empty) begin
                        sh       <= dout;
                        byte_idx <= '0;
                        tx       <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        tx      <= sh[0];
                        sh      <= sh >> 1;
                        state   <= DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        timer <= '0;
                        if (bit_idx == 3'(BITS_PER_BYTE - 1)) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= sh[0];
                            sh      <= sh >> 1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        timer <= '0;
                        if (byte_idx != 2'(BYTES_PER_WORD - 1)) begin
                            byte_idx <= byte_idx + 1'b1;
                            tx       <= 1'b0;
                            state    <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a0_uart_tx.sv
// Directed + random checks of a0_uart_tx against a line decoder.
module tb_a0_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] a0  = '0;
    logic        en  = 1'b0;
    logic        tx;
    logic        busy;
    logic        overflow;

    a0_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a0       (a0),
        .en       (en),
        .tx       (tx),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic [7:0]  rxq [$];
    int          stq [$];
    int          ferr = 0;
    logic [31:0] expq [$];
    logic [31:0] prev_m = '0;

    // Line decoder: samples mid-bit, records start cycle and byte.
    initial begin
        int         s;
        logic [7:0] b;
        logic       ok;
        forever begin
            @(negedge clk);
            if (rst && tx === 1'b0) begin
                s  = cyc;
                ok = 1'b1;
                repeat (CPB / 2) @(negedge clk);
                if (tx !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (tx !== 1'b1) ok = 1'b0;
                stq.push_back(s);
                rxq.push_back(b);
                if (!ok) ferr++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of a0/en and update the reference model.
    task automatic apply(logic [31:0] a, logic e);
        @(posedge clk);
        #1;
        a0 = a;
        en = e;
        if (e && a != prev_m) expq.push_back(a);
        if (e) prev_m = a;
    endtask

    task automatic wait_idle(string tag, int budget);
        int k;
        k = 0;
        repeat (3) @(negedge clk);
        while (k < budget) begin
            @(negedge clk);
            if (!busy) break;
            k++;
        end
        check({tag, "_idle"}, 32'(k < budget), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_words(string tag);
        int n;
        n = expq.size();
        check({tag, "_nbytes"}, rxq.size(), 32'(n * 4));
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (4 * i + j < rxq.size())
                    check($sformatf("%s_w%0d_b%0d", tag, i, j),
                          32'(rxq[4 * i + j]),
                          (expq[i] >> (8 * j)) & 32'hff);
            end
        end
        check({tag, "_frame"}, ferr, 32'd0);
        rxq.delete();
        stq.delete();
        expq.delete();
        ferr = 0;
    endtask

    initial begin
        int n;
        int k;
        int r;
        logic [31:0] a;
        logic e;

        // 1: reset and quiet line
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        apply(32'h0, 1'b1);
        k = 0;
        repeat (500) begin
            @(negedge clk);
            if (busy || !tx) k++;
        end
        check("t1_quiet", k, 0);
        check("t1_nostart", stq.size(), 0);

        // 2: single word, latency and busy drop
        apply(32'h000000A5, 1'b1);
        n = cyc;
        while (cyc < n + 2) @(negedge clk);
        check("t2_start_tx", tx, 0);
        check("t2_busy", busy, 1);
        while (cyc < n + 163) @(negedge clk);
        check("t2_busy_off", busy, 0);
        repeat (2) @(negedge clk);
        check("t2_start_cyc", stq.size() > 0 ? stq[0] : -1, n + 2);
        check_words("t2");

        // 3: burst of four, last one dropped
        apply(32'd1, 1'b1);
        apply(32'd2, 1'b1);
        apply(32'd3, 1'b1);
        apply(32'd4, 1'b1);
        void'(expq.pop_back());
        wait_idle("t3", 1000);
        check("t3_ovf", overflow, 1);
        check_words("t3");

        // 4: disabled capture, then one word
        for (int i = 0; i < 5; i++) apply($urandom, 1'b0);
        repeat (50) @(negedge clk);
        check("t4_nostart", stq.size(), 0);
        check("t4_busy", busy, 0);
        apply(32'h77, 1'b1);
        wait_idle("t4", 400);
        check_words("t4");

        // 6: back-to-back words
        apply(32'h11223344, 1'b1);
        apply(32'h11223344, 1'b1);
        apply(32'h55667788, 1'b1);
        wait_idle("t6", 800);
        check("t6_nstarts", stq.size(), 8);
        if (stq.size() >= 5)
            check("t6_gap", stq[4] - stq[0], 32'(40 * CPB + 1));
        check_words("t6");

        // random words, widely spaced
        for (int i = 0; i < 8; i++) begin
            r = $urandom_range(3);
            e = (r != 0);
            a = ($urandom_range(3) == 0) ? prev_m : $urandom;
            apply(a, e);
            repeat (200) @(negedge clk);
        end
        wait_idle("rand", 400);
        check_words("rand");

        // 5: async reset mid-frame
        a = 32'hDEADBEEF;
        if (prev_m == a) a = a ^ 32'h1;
        apply(a, 1'b1);
        repeat (55) @(posedge clk);
        #1;
        rst = 1'b0;
        a0 = '0;
        prev_m = '0;
        #1;
        check("t5_tx", tx, 1);
        check("t5_busy", busy, 0);
        check("t5_ovf", overflow, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        n = cyc;
        k = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy) k++;
        end
        check("t5_quiet", k, 0);
        k = 0;
        foreach (stq[i]) if (stq[i] >= n) k++;
        check("t5_noframe", k, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
